sync_tx: RTL



---
 rtl/sync_pkg.sv | 40 ++++
 rtl/sync_tx.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sync_pkg.sv
// Shared definitions for the sync-word transmitter and its receiver-side model:
// phase encodings, the default marker byte, the word layout and the checksum.
package sync_pkg;

    // Marker byte carried in the top byte of every sync word.
    localparam logic [7:0] SYNC_MARKER_DEF = 8'hA5;

    // Width of the single phase down-counter shared by SETUP, STROBE and HOLD.
    localparam int unsigned SYNC_PHASE_W = 16;

    // Transfer phases.
    typedef enum logic [1:0] {
        SYNC_IDLE   = 2'd0,
        SYNC_SETUP  = 2'd1,
        SYNC_STROBE = 2'd2,
        SYNC_HOLD   = 2'd3
    } sync_state_e;

    // Layout of the 32-bit word driven on the sync bus.
    typedef struct packed {
        logic [7:0]  marker;
        logic [15:0] cnt;
        logic [7:0]  chk;
    } sync_word_t;

    // XOR checksum over the marker and both bytes of the frame count.
    function automatic logic [7:0] sync_chk(input logic [7:0] marker, input logic [15:0] cnt);
        sync_chk = marker ^ cnt[15:8] ^ cnt[7:0];
    endfunction

    // Assemble a complete sync word for a given marker and frame count.
    function automatic sync_word_t sync_build(input logic [7:0] marker, input logic [15:0] cnt);
        sync_word_t w;
        w.marker = marker;
        w.cnt    = cnt;
        w.chk    = sync_chk(marker, cnt);
        sync_build = w;
    endfunction

endpackage

// File: rtl/sync_tx.sv
// Sync-word transmitter. On each accepted frame tick a new word
// {marker, frame count, checksum} is loaded onto sync_o, and a capture strobe
// srdyo is framed around it with programmable setup, pulse and hold times.
// Ticks arriving while a word is in flight queue one word; further ticks are
// counted as overruns.
module sync_tx
    import sync_pkg::*;
#(
    parameter logic [7:0]  MARKER    = SYNC_MARKER_DEF,
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned PULSE_CYC = 4,
    parameter int unsigned HOLD_CYC  = 2
) (
    input  logic        clk,
    input  logic        GlobalReset,
    input  logic        enable,
    input  logic        frame_tick,
    output logic [31:0] sync_o,
    output logic        srdyo,
    output logic        busy,
    output logic [7:0]  overrun_cnt
);

    // Phase encodings kept as plain constants mirroring the package enum.
    localparam logic [1:0] ST_IDLE   = SYNC_IDLE;
    localparam logic [1:0] ST_SETUP  = SYNC_SETUP;
    localparam logic [1:0] ST_STROBE = SYNC_STROBE;
    localparam logic [1:0] ST_HOLD   = SYNC_HOLD;

    // Reload values for the phase counter: a phase of N cycles counts N-1..0.
    localparam logic [SYNC_PHASE_W-1:0] SETUP_LOAD = SYNC_PHASE_W'(SETUP_CYC - 1);
    localparam logic [SYNC_PHASE_W-1:0] PULSE_LOAD = SYNC_PHASE_W'(PULSE_CYC - 1);
    localparam logic [SYNC_PHASE_W-1:0] HOLD_LOAD  = SYNC_PHASE_W'(HOLD_CYC - 1);

    localparam logic [7:0] OVR_MAX = 8'hFF;

    // Registered state.
    logic [1:0]              state;
    logic [SYNC_PHASE_W-1:0] phase;
    logic [15:0]             frame_cnt;
    logic                    pending;

    // Next-state values.
    logic [1:0]              state_n;
    logic [SYNC_PHASE_W-1:0] phase_n;
    logic [15:0]             frame_cnt_n;
    logic                    pending_n;
    logic [31:0]             sync_n;
    logic                    srdyo_n;
    logic                    busy_n;
    logic [7:0]              overrun_n;

    logic                    phase_done;
    logic                    load_word;
    sync_word_t              next_word;

    assign phase_done = (phase == {SYNC_PHASE_W{1'b0}});
    assign next_word  = sync_build(MARKER, frame_cnt);

    // Next-state logic: tick bookkeeping, phase sequencing and word loading.
    always_comb begin
        state_n     = state;
        phase_n     = phase;
        frame_cnt_n = frame_cnt;
        pending_n   = pending;
        sync_n      = sync_o;
        srdyo_n     = srdyo;
        busy_n      = busy;
        overrun_n   = overrun_cnt;
        load_word   = 1'b0;

        // Ticks while a word is in flight queue one word or count an overrun.
        // Disabling drops any queued word and ignores ticks altogether.
        if (!enable) begin
            pending_n = 1'b0;
        end else if (frame_tick && busy) begin
            if (!pending) begin
                pending_n = 1'b1;
            end else if (overrun_cnt != OVR_MAX) begin
                overrun_n = overrun_cnt + 8'd1;
            end else begin
                overrun_n = overrun_cnt;
            end
        end else begin
            pending_n = pending;
        end

        case (state)
            ST_IDLE: begin
                // A word queued on the closing HOLD edge is picked up here.
                if (enable && (frame_tick || pending)) begin
                    load_word = 1'b1;
                end else begin
                    load_word = 1'b0;
                end
            end
            ST_SETUP: begin
                if (phase_done) begin
                    state_n = ST_STROBE;
                    phase_n = PULSE_LOAD;
                    srdyo_n = 1'b1;
                end else begin
                    phase_n = phase - SYNC_PHASE_W'(1);
                end
            end
            ST_STROBE: begin
                if (phase_done) begin
                    state_n = ST_HOLD;
                    phase_n = HOLD_LOAD;
                    srdyo_n = 1'b0;
                end else begin
                    phase_n = phase - SYNC_PHASE_W'(1);
                end
            end
            ST_HOLD: begin
                if (phase_done) begin
                    if (pending && enable) begin
                        // Back-to-back: the queued word loads on this edge.
                        load_word = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                        busy_n  = 1'b0;
                    end
                end else begin
                    phase_n = phase - SYNC_PHASE_W'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
                phase_n = {SYNC_PHASE_W{1'b0}};
                srdyo_n = 1'b0;
                busy_n  = 1'b0;
            end
        endcase

        // Loading a word consumes any queued request and restarts the timing.
        if (load_word) begin
            sync_n      = next_word;
            frame_cnt_n = frame_cnt + 16'd1;
            pending_n   = 1'b0;
            state_n     = ST_SETUP;
            phase_n     = SETUP_LOAD;
            srdyo_n     = 1'b0;
            busy_n      = 1'b1;
        end else begin
            sync_n      = sync_n;
        end
    end

    // Control state registers; reset drops any transfer in progress.
    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            state     <= ST_IDLE;
            phase     <= {SYNC_PHASE_W{1'b0}};
            pending   <= 1'b0;
        end else begin
            state     <= state_n;
            phase     <= phase_n;
            pending   <= pending_n;
        end
    end

    // Frame counter: advances only on the edge a word is loaded, wraps silently.
    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            frame_cnt <= 16'h0000;
        end else if (load_word) begin
            frame_cnt <= frame_cnt_n;
        end else begin
            frame_cnt <= frame_cnt;
        end
    end

    // Registered outputs toward the capture block.
    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            sync_o      <= 32'h0000_0000;
            srdyo       <= 1'b0;
            busy        <= 1'b0;
            overrun_cnt <= 8'h00;
        end else begin
            sync_o      <= sync_n;
            srdyo       <= srdyo_n;
            busy        <= busy_n;
            overrun_cnt <= overrun_n;
        end
    end

endmodule
